// File: rtl/counter_modn_modes_if.sv
// Bus bundle for counter_modn_modes: control/data inputs and registered count outputs.
// The master drives enb/modo/data and the slave (the counter) drives Q/rco.
interface counter_modn_modes_if #(
    parameter int WIDTH = 4
) ();
    logic             enb;
    logic [1:0]       modo;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] Q;
    logic             rco;

    modport master (output enb, modo, data, input Q, rco);
    modport slave  (input enb, modo, data, output Q, rco);
endinterface

// File: rtl/counter_modn_modes.sv
// Modulo-(MAX+1) counter with up, down, down-by-STEP and clamped load modes.
// rco is a registered one-cycle pulse on every wrap-around.
module counter_modn_modes #(
    parameter int WIDTH = 4,
    parameter int MAX   = (1 << WIDTH) - 1,
    parameter int STEP  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_modn_modes_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_UP    = 2'd0,
        MODE_DOWN  = 2'd1,
        MODE_STEP  = 2'd2,
        MODE_LOAD  = 2'd3
    } mode_e;

    // All compares and sums are WIDTH+1 bits wide so MAX+1 is representable.
    localparam int              WRAP_INT = MAX + 1 - STEP;
    localparam logic [WIDTH:0]  MAX_EXT  = MAX[WIDTH:0];
    localparam logic [WIDTH:0]  STEP_EXT = STEP[WIDTH:0];
    localparam logic [WIDTH:0]  WRAP_ADD = WRAP_INT[WIDTH:0];
    localparam logic [WIDTH:0]  ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]  ZERO_EXT = '0;

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   data_ext;
    logic [WIDTH:0]   next_ext;
    mode_e            mode;

    assign q_ext    = {1'b0, q_q};
    assign data_ext = {1'b0, bus.data};
    assign mode     = mode_e'(bus.modo);

    always_comb begin
        next_ext = q_ext;
        rco_d    = 1'b0;
        if (bus.enb) begin
            unique case (mode)
                MODE_UP: begin
                    if (q_ext > MAX_EXT) begin
                        next_ext = ZERO_EXT;
                    end else if (q_ext == MAX_EXT) begin
                        next_ext = ZERO_EXT;
                        rco_d    = 1'b1;
                    end else begin
                        next_ext = q_ext + ONE_EXT;
                    end
                end
                MODE_DOWN: begin
                    if (q_ext > MAX_EXT) begin
                        next_ext = ZERO_EXT;
                    end else if (q_ext == ZERO_EXT) begin
                        next_ext = MAX_EXT;
                        rco_d    = 1'b1;
                    end else begin
                        next_ext = q_ext - ONE_EXT;
                    end
                end
                MODE_STEP: begin
                    if (q_ext > MAX_EXT) begin
                        next_ext = ZERO_EXT;
                    end else if (q_ext >= STEP_EXT) begin
                        next_ext = q_ext - STEP_EXT;
                    end else begin
                        // q < STEP, so q + (MAX+1) - STEP lands in 0..MAX
                        next_ext = q_ext + WRAP_ADD;
                        rco_d    = 1'b1;
                    end
                end
                MODE_LOAD: begin
                    next_ext = (data_ext > MAX_EXT) ? MAX_EXT : data_ext;
                end
                default: begin
                    next_ext = q_ext;
                end
            endcase
        end
        q_d = next_ext[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign bus.Q   = q_q;
    assign bus.rco = rco_q;

endmodule

// File: tb/tb_counter_modn_modes.sv
// Directed bench for counter_modn_modes with WIDTH=4, MAX=9, STEP=3.
module tb_counter_modn_modes;

    localparam int WIDTH = 4;
    localparam int MAX   = 9;
    localparam int STEP  = 3;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    counter_modn_modes_if #(.WIDTH(WIDTH)) bus ();

    counter_modn_modes #(
        .WIDTH (WIDTH),
        .MAX   (MAX),
        .STEP  (STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] exp_q, input logic exp_rco);
        tests_run++;
        assert ({bus.Q, bus.rco} === {exp_q, exp_rco}) else begin
            tests_failed++;
            $error("FAIL %s: observed Q=%0d rco=%0b, expected Q=%0d rco=%0b",
                   tag, bus.Q, bus.rco, exp_q, exp_rco);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] value);
        bus.enb  = 1'b1;
        bus.modo = 2'd3;
        bus.data = value;
        tick();
    endtask

    initial begin
        int up_exp  [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        int dn_exp  [3]  = '{0, 9, 8};
        int dn_rco  [3]  = '{0, 1, 0};
        int st_exp  [6]  = '{4, 1, 8, 5, 2, 9};
        int st_rco  [6]  = '{0, 0, 1, 0, 0, 1};

        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        bus.enb  = 1'b0;
        bus.modo = 2'd0;
        bus.data = '0;

        tick();
        tick();
        check("reset_state", 4'd0, 1'b0);
        rst = 1'b1;

        // Count to 5, then assert reset between edges
        bus.enb  = 1'b1;
        bus.modo = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("pre_reset_up_%0d", i), 4'(i), 1'b0);
        end
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_clear", 4'd0, 1'b0);
        tick();
        check("reset_held_over_edge", 4'd0, 1'b0);
        rst = 1'b1;
        tick();
        check("first_edge_after_reset", 4'd1, 1'b0);

        // Up wrap through MAX
        load(4'd0);
        check("load_zero", 4'd0, 1'b0);
        bus.modo = 2'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("up_wrap_%0d", i), 4'(up_exp[i]), (i == 9));
        end
        tick();
        check("up_after_wrap_rco_single", 4'd1, 1'b0);

        // Down wrap through zero
        load(4'd1);
        check("load_one", 4'd1, 1'b0);
        bus.modo = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("down_%0d", i), 4'(dn_exp[i]), dn_rco[i][0]);
        end

        // Down by STEP with modulo wrap
        load(4'd7);
        check("load_seven", 4'd7, 1'b0);
        bus.modo = 2'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("step_%0d", i), 4'(st_exp[i]), st_rco[i][0]);
        end

        // Clamped load
        load(4'd14);
        check("load_clamp_14", 4'd9, 1'b0);
        load(4'd6);
        check("load_6", 4'd6, 1'b0);
        load(4'd15);
        check("load_clamp_15", 4'd9, 1'b0);
        load(4'd10);
        check("load_clamp_10", 4'd9, 1'b0);
        load(4'd9);
        check("load_max", 4'd9, 1'b0);

        // Disabled edge clears a pending rco
        bus.modo = 2'd0;
        tick();
        check("wrap_before_disable", 4'd0, 1'b1);
        bus.enb = 1'b0;
        tick();
        check("disable_clears_rco", 4'd0, 1'b0);

        // Enable hold while modo/data wiggle
        load(4'd4);
        check("load_four", 4'd4, 1'b0);
        bus.enb  = 1'b0;
        bus.data = 4'd2;
        for (int i = 0; i < 5; i++) begin
            bus.modo = 2'(i % 4);
            tick();
            check($sformatf("hold_%0d", i), 4'd4, 1'b0);
        end
        bus.enb  = 1'b1;
        bus.modo = 2'd0;
        tick();
        check("reenable_up", 4'd5, 1'b0);

        // Mode change takes effect on the next edge
        bus.modo = 2'd1;
        tick();
        check("mode_switch_down", 4'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
